common_dffram_wrctrl: RTL

- Write-port controller for the DFF-based 1W2R RAM.
- Shares the single write port between two requesters using a valid/ready handshake and registers the winning write.
- After reset, and on demand, sweeps the whole RAM to a fill value.
- Sits between producer logic (e.g. issue/writeback) and the RAM port A; RAM read ports B/C are untouched.

---
 rtl/common_dffram_wrctrl_pkg.sv | 16 +
 rtl/common_dffram_wrctrl_if.sv | 28 ++
 rtl/common_arbiter_rr2.sv | 45 ++++
 rtl/common_dffram_wrctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/common_dffram_wrctrl_pkg.sv
// rtl/common_dffram_wrctrl_pkg.sv - shared FSM encoding and grant constants for the DFF-RAM write controller
package common_dffram_wrctrl_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/common_dffram_wrctrl_if.sv
// rtl/common_dffram_wrctrl_if.sv - two-requester write handshake bundle
interface common_dffram_wrctrl_if #(
  parameter int DW = 1,
  parameter int AW = 1
);

  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/common_arbiter_rr2.sv
// rtl/common_arbiter_rr2.sv - 2-way arbiter; round-robin with COMMON_DFFRAM_WRCTRL_RR_EN, else fixed priority
module common_arbiter_rr2
  import common_dffram_wrctrl_pkg::*;
(
`ifdef COMMON_DFFRAM_WRCTRL_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

`ifdef COMMON_DFFRAM_WRCTRL_RR_EN
  logic last;

  // Pointer moves only on a real handshake, so a stalled grant keeps its turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= GRANT_REQ1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = grant_onehot(~last);
    end else begin
      grant = valid;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (valid[0]) begin
      grant = grant_onehot(GRANT_REQ0);
    end else if (valid[1]) begin
      grant = grant_onehot(GRANT_REQ1);
    end
  end
`endif

endmodule

// File: rtl/common_dffram_wrctrl.sv
// rtl/common_dffram_wrctrl.sv - DFF-RAM write-port controller: fill sweep plus 2-requester arbitration (COMMON_DFFRAM_WRCTRL_RR_EN)
module common_dffram_wrctrl
  import common_dffram_wrctrl_pkg::*;
#(
  parameter int                     RAM_DATA_WIDTH = 1,
  parameter int                     RAM_ADDR_WIDTH = 1,
  parameter logic [RAM_DATA_WIDTH-1:0] RAM_FILL_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  common_dffram_wrctrl_if.slave     req,
  input  logic                      clear_req,
  output logic                      init_done,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [RAM_DATA_WIDTH-1:0] ram_dina
);

  state_t                    state;
  state_t                    state_nxt;
  logic [RAM_ADDR_WIDTH-1:0] cnt;
  logic [RAM_ADDR_WIDTH-1:0] cnt_nxt;
  logic [1:0]                valid;
  logic [1:0]                grant;
  logic [1:0]                ready;
  logic                      accept;
  logic                      wr_q;

  assign valid  = {req.req1_valid, req.req0_valid};
  assign accept = |ready;

  common_arbiter_rr2 u_arb (
`ifdef COMMON_DFFRAM_WRCTRL_RR_EN
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
`endif
    .valid  (valid),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter wraps naturally from all-ones to zero as the sweep ends.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 2'b00;
    case (state)
      ST_SWEEP: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nxt = ST_SWEEP;
          cnt_nxt   = '0;
        end else begin
          ready = grant & valid;
        end
      end
      default: begin
        state_nxt = ST_SWEEP;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign req.req0_ready = ready[0];
  assign req.req1_ready = ready[1];
  assign init_done      = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q      <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
    end else if (state == ST_SWEEP) begin
      wr_q      <= 1'b1;
      ram_addra <= cnt;
      ram_dina  <= RAM_FILL_VALUE;
    end else if (accept) begin
      wr_q      <= 1'b1;
      ram_addra <= ready[1] ? req.req1_addr : req.req0_addr;
      ram_dina  <= ready[1] ? req.req1_data : req.req0_data;
    end else begin
      wr_q      <= 1'b0;
    end
  end

  assign ram_ena = wr_q;
  assign ram_wea = wr_q;

endmodule
